// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman query ingress stage.
// Header field offsets, FSM state encoding, command record and word-count helper.
// No logic of its own; imported by sw_query_parser.
package sw_pkg;

   localparam int SW_WORD_W      = 128;
   localparam int BASES_PER_WORD = 64;
   localparam int BASES_SHIFT    = $clog2(BASES_PER_WORD);

   // Header word layout; bits [95:80] and [127:112] carry nothing we use.
   localparam int HDR_REF_WORDS_LSB = 0;
   localparam int HDR_REF_WORDS_W   = 32;
   localparam int HDR_REF_ADDR_LSB  = 32;
   localparam int HDR_REF_ADDR_W    = 32;
   localparam int HDR_QUERY_LEN_LSB = 64;
   localparam int HDR_QUERY_LEN_W   = 16;
   localparam int HDR_THRESHOLD_LSB = 96;
   localparam int HDR_THRESHOLD_W   = 16;

   typedef enum logic [1:0] {
      HDR = 2'd0,
      CMD = 2'd1,
      QRY = 2'd2
   } sw_qp_state_t;

   typedef struct packed {
      logic [HDR_REF_WORDS_W-1:0] ref_words;
      logic [HDR_REF_ADDR_W-1:0]  ref_addr;
      logic [HDR_QUERY_LEN_W-1:0] query_len;
      logic [HDR_THRESHOLD_W-1:0] threshold;
   } sw_cmd_t;

   // Number of 128-bit query words needed for len bases, i.e. ceil(len/64).
   function automatic logic [15:0] words_for_len(input logic [15:0] len);
      return 16'(({1'b0, len} + 17'(BASES_PER_WORD - 1)) >> BASES_SHIFT);
   endfunction

endpackage

// File: rtl/sw_stream_reg.sv
// Single-entry valid/ready register slice.
// Latency: one cycle from input handshake to out_vld.
// Backpressure: in_rdy = ~out_vld | out_rdy (only combinational path is out_rdy -> in_rdy).
module sw_stream_reg #(
   parameter int W = 129
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_vld,
   output logic         in_rdy,
   input  logic [W-1:0] in_dat,
   output logic         out_vld,
   input  logic         out_rdy,
   output logic [W-1:0] out_dat
);

   assign in_rdy = ~out_vld | out_rdy;

   // Load a new word whenever the slot is free or being drained; otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld <= 1'b0;
         out_dat <= '0;
      end else if (in_rdy) begin
         out_vld <= in_vld;
         if (in_vld) begin
            out_dat <= in_dat;
         end
      end
   end

endmodule

// File: rtl/sw_query_parser.sv
// Ingress parser: decodes a query header, issues one alignment command, then forwards the query words with a last marker.
// Latency: header -> cmd_valid 1 cycle; query word -> q_valid 1 cycle; 1 word/cycle sustained.
// Backpressure: si_rdy low in CMD; in QRY si_rdy follows the output slot (~q_valid | q_ready). Optional counters: SW_QPARSE_STATS_EN.
module sw_query_parser
   import sw_pkg::*;
#(
   parameter int MAX_QUERY_LEN = 256,
   parameter int ID_W          = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 si_valid,
   output logic                 si_rdy,
   input  logic [127:0]         si_data,
   output logic                 cmd_valid,
   input  logic                 cmd_ready,
   output logic [31:0]          cmd_ref_words,
   output logic [31:0]          cmd_ref_addr,
   output logic [15:0]          cmd_query_len,
   output logic [15:0]          cmd_threshold,
   output logic [ID_W-1:0]      cmd_query_id,
   output logic                 q_valid,
   input  logic                 q_ready,
   output logic [127:0]         q_data,
   output logic                 q_last,
   output logic                 hdr_err
`ifdef SW_QPARSE_STATS_EN
   ,
   output logic [31:0]          stat_queries,
   output logic [31:0]          stat_rejects
`endif
);

   localparam int MAX_WORDS = MAX_QUERY_LEN / BASES_PER_WORD;
   localparam int CNT_W     = $clog2(MAX_WORDS + 1);

   sw_qp_state_t     state_q, state_d;
   sw_cmd_t          cmd_q;
   logic [ID_W-1:0]  qid_q;
   logic [CNT_W-1:0] words_left_q;
   logic             hdr_err_q;
   logic             alive_q;

   logic [HDR_REF_WORDS_W-1:0] hdr_ref_words;
   logic [HDR_REF_ADDR_W-1:0]  hdr_ref_addr;
   logic [HDR_QUERY_LEN_W-1:0] hdr_query_len;
   logic [HDR_THRESHOLD_W-1:0] hdr_threshold;
   logic                       hdr_ok;
   logic                       hdr_accept;
   logic                       hdr_reject;
   logic                       cmd_fire;
   logic                       qry_more;
   logic                       slice_in_vld;
   logic                       slice_in_rdy;
   logic [SW_WORD_W:0]         slice_out;
   logic                       unused_hdr_bits;

   assign hdr_ref_words = si_data[HDR_REF_WORDS_LSB +: HDR_REF_WORDS_W];
   assign hdr_ref_addr  = si_data[HDR_REF_ADDR_LSB  +: HDR_REF_ADDR_W];
   assign hdr_query_len = si_data[HDR_QUERY_LEN_LSB +: HDR_QUERY_LEN_W];
   assign hdr_threshold = si_data[HDR_THRESHOLD_LSB +: HDR_THRESHOLD_W];
   assign unused_hdr_bits = ^{si_data[95:80], si_data[127:112]};

   assign hdr_ok = (hdr_query_len != '0) &&
                   (hdr_query_len <= 16'(MAX_QUERY_LEN)) &&
                   (hdr_ref_words != '0);

   // Words still to be taken from the input; zero means the last one is already in the output slot.
   assign qry_more = (words_left_q != '0);

   // Next state and handshake strobes; si_rdy is held low until the first clock after reset release.
   always_comb begin
      state_d      = state_q;
      si_rdy       = 1'b0;
      cmd_valid    = 1'b0;
      slice_in_vld = 1'b0;
      hdr_accept   = 1'b0;
      hdr_reject   = 1'b0;
      cmd_fire     = 1'b0;
      case (state_q)
         HDR: begin
            si_rdy = alive_q;
            if (alive_q && si_valid) begin
               if (hdr_ok) begin
                  hdr_accept = 1'b1;
                  state_d    = CMD;
               end else begin
                  hdr_reject = 1'b1;
               end
            end
         end
         CMD: begin
            cmd_valid = 1'b1;
            if (cmd_ready) begin
               cmd_fire = 1'b1;
               state_d  = QRY;
            end
         end
         QRY: begin
            si_rdy       = qry_more & slice_in_rdy;
            slice_in_vld = qry_more & si_valid;
            if (!qry_more && q_valid && q_ready) begin
               state_d = HDR;
            end
         end
         default: state_d = HDR;
      endcase
   end

   // State register plus the post-reset enable for si_rdy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= HDR;
         alive_q <= 1'b0;
      end else begin
         state_q <= state_d;
         alive_q <= 1'b1;
      end
   end

   // Command fields are captured only from accepted headers, so they stay stable through CMD.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_q <= '0;
      end else if (hdr_accept) begin
         cmd_q.ref_words <= hdr_ref_words;
         cmd_q.ref_addr  <= hdr_ref_addr;
         cmd_q.query_len <= hdr_query_len;
         cmd_q.threshold <= hdr_threshold;
      end
   end

   // Query ID advances only on a command handshake and wraps naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qid_q <= '0;
      end else if (cmd_fire) begin
         qid_q <= qid_q + 1'b1;
      end
   end

   // Word counter: loaded when the command goes out, decremented per accepted query word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         words_left_q <= '0;
      end else if (cmd_fire) begin
         words_left_q <= CNT_W'(words_for_len(cmd_q.query_len));
      end else if (slice_in_vld && slice_in_rdy) begin
         words_left_q <= words_left_q - 1'b1;
      end
   end

   // Sticky header-reject flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hdr_err_q <= 1'b0;
      end else if (hdr_reject) begin
         hdr_err_q <= 1'b1;
      end
   end

   sw_stream_reg #(.W(SW_WORD_W + 1)) u_q_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_vld  (slice_in_vld),
      .in_rdy  (slice_in_rdy),
      .in_dat  ({(words_left_q == CNT_W'(1)), si_data}),
      .out_vld (q_valid),
      .out_rdy (q_ready),
      .out_dat (slice_out)
   );

   assign q_last        = slice_out[SW_WORD_W];
   assign q_data        = slice_out[SW_WORD_W-1:0];
   assign cmd_ref_words = cmd_q.ref_words;
   assign cmd_ref_addr  = cmd_q.ref_addr;
   assign cmd_query_len = cmd_q.query_len;
   assign cmd_threshold = cmd_q.threshold;
   assign cmd_query_id  = qid_q;
   assign hdr_err       = hdr_err_q;

`ifdef SW_QPARSE_STATS_EN
   // Saturating counters of issued commands and rejected headers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_queries <= '0;
         stat_rejects <= '0;
      end else begin
         if (cmd_fire && (stat_queries != '1)) begin
            stat_queries <= stat_queries + 32'd1;
         end
         if (hdr_reject && (stat_rejects != '1)) begin
            stat_rejects <= stat_rejects + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_sw_query_parser.sv
module tb_sw_query_parser;

   localparam int IDW = 16;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           si_valid;
   logic           si_rdy;
   logic [127:0]   si_data;
   logic           cmd_valid;
   logic           cmd_ready;
   logic [31:0]    cmd_ref_words;
   logic [31:0]    cmd_ref_addr;
   logic [15:0]    cmd_query_len;
   logic [15:0]    cmd_threshold;
   logic [IDW-1:0] cmd_query_id;
   logic           q_valid;
   logic           q_ready;
   logic [127:0]   q_data;
   logic           q_last;
   logic           hdr_err;
`ifdef SW_QPARSE_STATS_EN
   logic [31:0]    stat_queries;
   logic [31:0]    stat_rejects;
`endif

   always #5 clk = ~clk;

   sw_query_parser #(.MAX_QUERY_LEN(256), .ID_W(IDW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .si_valid      (si_valid),
      .si_rdy        (si_rdy),
      .si_data       (si_data),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_ref_words (cmd_ref_words),
      .cmd_ref_addr  (cmd_ref_addr),
      .cmd_query_len (cmd_query_len),
      .cmd_threshold (cmd_threshold),
      .cmd_query_id  (cmd_query_id),
      .q_valid       (q_valid),
      .q_ready       (q_ready),
      .q_data        (q_data),
      .q_last        (q_last),
      .hdr_err       (hdr_err)
`ifdef SW_QPARSE_STATS_EN
      ,
      .stat_queries  (stat_queries),
      .stat_rejects  (stat_rejects)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Observed handshakes, captured on the active edge before the DUT state updates.
   logic [127:0] qd_q[$];
   logic         ql_q[$];
   logic [111:0] cmd_q[$];

   always @(posedge clk) begin
      if (rst_n && q_valid && q_ready) begin
         qd_q.push_back(q_data);
         ql_q.push_back(q_last);
      end
      if (rst_n && cmd_valid && cmd_ready) begin
         cmd_q.push_back({cmd_ref_words, cmd_ref_addr, cmd_query_len, cmd_threshold, cmd_query_id});
      end
   end

   function automatic logic [111:0] mk_cmd(input logic [31:0] rw, input logic [31:0] ra,
                                           input logic [15:0] ql, input logic [15:0] th,
                                           input logic [15:0] id);
      return {rw, ra, ql, th, id};
   endfunction

   // Reserved fields filled with junk that must be ignored.
   function automatic logic [127:0] mk_hdr(input logic [31:0] rw, input logic [31:0] ra,
                                           input logic [15:0] ql, input logic [15:0] th);
      return {16'hDEAD, th, 16'hBEEF, ql, ra, rw};
   endfunction

   function automatic logic [127:0] mk_word(input int a, input int b);
      return {32'(a), 32'hC0FFEE00 ^ 32'(b), 32'(a * 7 + b), 32'h5A5A0000 | 32'(b)};
   endfunction

   // Called on a falling edge; returns on the falling edge after the word is accepted, si_valid left high.
   task automatic push_word(input logic [127:0] w, output int waits);
      si_data  = w;
      si_valid = 1'b1;
      waits    = 0;
      forever begin
         #1;
         if (si_rdy) begin
            @(negedge clk);
            return;
         end
         waits++;
         if (waits > 200) begin
            check("push_rdy_timeout", si_rdy, 1'b1);
            si_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
   endtask

   task automatic drain(input string tag);
      logic idle;
      si_valid = 1'b0;
      idle     = 1'b0;
      for (int i = 0; i < 200; i++) begin
         #1;
         idle = si_rdy & ~q_valid & ~cmd_valid;
         if (idle) break;
         @(negedge clk);
      end
      check(tag, idle, 1'b1);
      @(negedge clk);
   endtask

   task automatic clear_obs();
      qd_q.delete();
      ql_q.delete();
      cmd_q.delete();
   endtask

   logic [127:0] exp_w;
   logic [15:0]  exp_id;
   int           exp_good;
   int           exp_bad;
   int           w;
   bit           toggle_en;

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      si_valid  = 1'b0;
      si_data   = '0;
      cmd_ready = 1'b0;
      q_ready   = 1'b0;
      toggle_en = 1'b0;
      exp_id    = 16'd0;
      exp_good  = 0;
      exp_bad   = 0;

      // ---- reset values ----
      repeat (3) @(negedge clk);
      #1;
      check("rst_si_rdy", si_rdy, 1'b0);
      check("rst_cmd_valid", cmd_valid, 1'b0);
      check("rst_q_valid", q_valid, 1'b0);
      check("rst_q_last", q_last, 1'b0);
      check("rst_hdr_err", hdr_err, 1'b0);
      check("rst_cmd_fields", {cmd_ref_words, cmd_ref_addr, cmd_query_len, cmd_threshold, cmd_query_id}, '0);
      check("rst_q_data", q_data, '0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      check("rel_si_rdy", si_rdy, 1'b1);
      @(negedge clk);

      // ---- single 64-base query ----
      cmd_ready = 1'b1;
      q_ready   = 1'b1;
      exp_w     = 128'hc8facaa7c280aa28a020aaaf89aae004;
      push_word(128'h00000080_00000040_00000000_00000008, w);
      si_valid = 1'b0;
      #1;
      check("t1_cmd_valid_n1", cmd_valid, 1'b1);
      check("t1_si_rdy_in_cmd", si_rdy, 1'b0);
      @(negedge clk);
      push_word(exp_w, w);
      check("t1_si_rdy_after_cmd", w, 0);
      si_valid = 1'b0;
      #1;
      check("t1_q_valid_k1", q_valid, 1'b1);
      check("t1_q_last", q_last, 1'b1);
      check("t1_q_data", q_data, exp_w);
      @(negedge clk);
      drain("t1_idle");
      check("t1_nwords", qd_q.size(), 1);
      if (qd_q.size() == 1) begin
         check("t1_word", qd_q[0], exp_w);
         check("t1_last", ql_q[0], 1'b1);
      end
      check("t1_ncmd", cmd_q.size(), 1);
      if (cmd_q.size() == 1) check("t1_cmd", cmd_q[0], mk_cmd(32'd8, 32'd0, 16'd64, 16'd128, exp_id));
      exp_id++;
      clear_obs();

      // ---- two back-to-back 200-base queries (4 words each) ----
      for (int q = 0; q < 2; q++) begin
         push_word(mk_hdr(32'(3 + q), 32'h1000 * 32'(q + 1), 16'd200, 16'(50 + q)), w);
         for (int k = 0; k < 4; k++) begin
            push_word(mk_word(q, k), w);
            if (k > 0) check("t2_rate", w, 0);
         end
      end
      drain("t2_idle");
      check("t2_nwords", qd_q.size(), 8);
      if (qd_q.size() == 8) begin
         for (int i = 0; i < 8; i++) begin
            check("t2_word", qd_q[i], mk_word(i / 4, i % 4));
            check("t2_last", ql_q[i], (i % 4) == 3);
         end
      end
      check("t2_ncmd", cmd_q.size(), 2);
      if (cmd_q.size() == 2) begin
         check("t2_cmd0", cmd_q[0], mk_cmd(32'd3, 32'h1000, 16'd200, 16'd50, exp_id));
         check("t2_cmd1", cmd_q[1], mk_cmd(32'd4, 32'h2000, 16'd200, 16'd51, exp_id + 16'd1));
      end
      exp_id += 16'd2;
      clear_obs();

      // ---- cmd_ready held low, q_ready toggling ----
      cmd_ready = 1'b0;
      push_word(mk_hdr(32'd7, 32'hABCD0000, 16'd130, 16'd9), w);
      si_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         check("t3_cmd_valid_hold", cmd_valid, 1'b1);
         check("t3_si_rdy_cmd", si_rdy, 1'b0);
         check("t3_fields_stable", {cmd_ref_words, cmd_ref_addr, cmd_query_len, cmd_threshold, cmd_query_id},
               mk_cmd(32'd7, 32'hABCD0000, 16'd130, 16'd9, exp_id));
         @(negedge clk);
      end
      toggle_en = 1'b1;
      fork
         begin
            while (toggle_en) begin
               @(negedge clk);
               if (toggle_en) q_ready = ~q_ready;
            end
         end
      join_none
      cmd_ready = 1'b1;
      for (int k = 0; k < 3; k++) push_word(mk_word(9, k), w);
      drain("t3_idle");
      toggle_en = 1'b0;
      q_ready   = 1'b1;
      check("t3_nwords", qd_q.size(), 3);
      if (qd_q.size() == 3) begin
         for (int i = 0; i < 3; i++) begin
            check("t3_word", qd_q[i], mk_word(9, i));
            check("t3_last", ql_q[i], i == 2);
         end
      end
      check("t3_ncmd", cmd_q.size(), 1);
      exp_id++;
      clear_obs();

      // ---- reset while two words are outstanding ----
      q_ready = 1'b0;
      push_word(mk_hdr(32'd1, 32'h55, 16'd256, 16'd3), w);
      push_word(mk_word(5, 0), w);
      si_data = mk_word(5, 1);
      @(negedge clk);
      #1;
      check("t4_pre_q_valid", q_valid, 1'b1);
      check("t4_pre_stall", si_rdy, 1'b0);
      rst_n = 1'b0;
      #1;
      check("t4_rst_q_valid", q_valid, 1'b0);
      check("t4_rst_q_last", q_last, 1'b0);
      check("t4_rst_q_data", q_data, '0);
      check("t4_rst_si_rdy", si_rdy, 1'b0);
      check("t4_rst_cmd", {cmd_valid, cmd_ref_words, cmd_ref_addr, cmd_query_len, cmd_threshold, cmd_query_id}, '0);
      si_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      clear_obs();
      exp_id = 16'd0;
      q_ready = 1'b1;
      @(negedge clk);

      // ---- rejected headers, then fresh valid ones ----
      push_word(mk_hdr(32'd4, 32'd0, 16'd0, 16'd0), w);
      si_valid = 1'b0;
      exp_bad++;
      #1;
      check("t5_hdr_err_len0", hdr_err, 1'b1);
      check("t5_no_cmd_len0", cmd_valid, 1'b0);
      @(negedge clk);
      push_word(mk_hdr(32'd4, 32'd0, 16'd257, 16'd0), w);
      si_valid = 1'b0;
      exp_bad++;
      #1;
      check("t5_no_cmd_len257", cmd_valid, 1'b0);
      @(negedge clk);
      push_word(mk_hdr(32'd0, 32'd0, 16'd64, 16'd0), w);
      si_valid = 1'b0;
      exp_bad++;
      #1;
      check("t5_no_cmd_ref0", cmd_valid, 1'b0);
      @(negedge clk);
      check("t5_no_cmds", cmd_q.size(), 0);

      push_word(mk_hdr(32'd2, 32'h40, 16'd64, 16'd1), w);
      push_word(mk_word(6, 0), w);
      exp_good++;
      push_word(mk_hdr(32'd9, 32'h100, 16'd256, 16'd77), w);
      for (int k = 0; k < 4; k++) push_word(mk_word(7, k), w);
      exp_good++;
      drain("t5_idle");
      check("t5_ncmd", cmd_q.size(), 2);
      if (cmd_q.size() == 2) begin
         check("t5_cmd_fresh", cmd_q[0], mk_cmd(32'd2, 32'h40, 16'd64, 16'd1, exp_id));
         check("t5_cmd_max", cmd_q[1], mk_cmd(32'd9, 32'h100, 16'd256, 16'd77, exp_id + 16'd1));
      end
      check("t5_nwords", qd_q.size(), 5);
      if (qd_q.size() == 5) begin
         check("t5_word0", qd_q[0], mk_word(6, 0));
         check("t5_last0", ql_q[0], 1'b1);
         for (int i = 1; i < 5; i++) begin
            check("t5_word", qd_q[i], mk_word(7, i - 1));
            check("t5_last", ql_q[i], i == 4);
         end
      end
      check("t5_hdr_err_sticky", hdr_err, 1'b1);

`ifdef SW_QPARSE_STATS_EN
      check("stat_queries", stat_queries, 32'(exp_good));
      check("stat_rejects", stat_rejects, 32'(exp_bad));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sw_query_parser.md
# sw_query_parser

Ingress stage of the Smith-Waterman accelerator, directly downstream of host input stream 1. It:
- accepts 128-bit PicoStream words;
- decodes the per-query header word;
- issues one alignment command (ref DRAM window, query length, score threshold, tagged query ID) to the SW core;
- forwards the packed 2-bit-per-base query words behind the command, framed with a last marker.

## Interface
Parameters:
- MAX_QUERY_LEN, 256, largest accepted query length in bases (multiple of 64)
- ID_W, 16, query ID width

Ports:
- clk  in  1  stream/core clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- si_valid  in  1  input stream word valid
- si_rdy  out  1  input stream ready
- si_data  in  128  input stream word
- cmd_valid  out  1  command valid
- cmd_ready  in  1  core accepts command
- cmd_ref_words  out  32  ref length in 256-bit DRAM words (header [31:0])
- cmd_ref_addr  out  32  ref byte address in DDR3_0 (header [63:32])
- cmd_query_len  out  16  query length in bases (header [79:64])
- cmd_threshold  out  16  minimum reportable score (header [111:96])
- cmd_query_id  out  ID_W  sequence number of this query
- q_valid  out  1  query word valid
- q_ready  in  1  core accepts query word
- q_data  out  128  query word, base 0 in bits [1:0]
- q_last  out  1  final query word of this command
- hdr_err  out  1  sticky: a header was rejected; cleared only by reset

## Operation
- FSM states: HDR, CMD, QRY.
- HDR:
  - si_rdy=1.
  - On handshake, latch fields.
  - Header valid iff query_len in 1..MAX_QUERY_LEN and ref_words != 0.
  - Valid header → CMD. Invalid → set hdr_err, drop word, stay in HDR.
  - Header bits [95:80] and [127:112] are ignored.
- CMD:
  - si_rdy=0, cmd_valid=1, fields stable.
  - On cmd handshake: qid increments (wraps at 2^ID_W), word counter loads ceil(query_len/64), state → QRY.
- QRY:
  - si_rdy = ~q_valid | q_ready (one-entry output register).
  - Each accepted input word is loaded into q_data/q_valid.
  - q_last is set on the final counted word.
  - When the q_last word handshakes on q and no word is pending, state → HDR.
  - Bases past query_len in the last word are passed unmodified; the core masks them.
- Query ID:
  - 0 after reset; the first command carries ID 0.
  - Never advances on rejected headers.
- Reset mid-operation: all state is discarded asynchronously; the FSM returns to HDR.

## Timing
- Reset values:
  - si_rdy=0 while rst_n low, 1 in first cycle after release.
  - cmd_valid=0, q_valid=0, q_last=0, hdr_err=0.
  - All cmd_* fields and q_data = 0; qid=0.
- Header handshake at cycle N → cmd_valid=1 at N+1.
- cmd handshake at cycle M → si_rdy=1 at M+1.
- Input word handshake at cycle K → q_valid=1 at K+1.
- Sustains 1 word/cycle when q_ready is held high.
- q_valid/q_data/q_last hold until q_ready; no combinational path from si_valid to q_valid.
- Only q_ready→si_rdy is combinational.
- Final word: si_rdy drops the cycle after the last input word is accepted. The earliest next header handshake is the cycle after the q_last handshake.

## Configuration
- SW_QPARSE_STATS_EN defined adds two outputs:
  - stat_queries[31:0]: count of cmd handshakes.
  - stat_rejects[31:0]: count of rejected headers.
  - Both reset to 0 and saturate at 0xFFFFFFFF.
- Macro undefined: ports and counters absent; all other behaviour identical.

## Structure
- Package sw_pkg:
  - header field offsets/widths;
  - state enum sw_qp_state_t {HDR, CMD, QRY};
  - BASES_PER_WORD=64;
  - HDR_* localparams.
- One sub-module, sw_stream_reg: single-entry valid/ready register slice carrying {q_last, q_data}, used for the query output.

## Test plan
- Header 128'h00000080_00000040_00000000_00000008, then query 128'hc8facaa7c280aa28a020aaaf89aae004:
  - cmd: ref_words=8, ref_addr=0, query_len=64, threshold=128, id=0;
  - one q word equal to the input, with q_last=1.
- Two back-to-back queries with query_len=200 → 4 words each; q_last only on the 4th word; second command id=1.
- q_ready toggled 1/0 every cycle and cmd_ready held low 5 cycles → no word lost or duplicated; si_rdy=0 throughout CMD; cmd fields stable.
- Rejected headers:
  - header query_len=0 → hdr_err=1, no cmd issued;
  - next valid header → cmd id=0;
  - query_len=257 behaves the same.
- rst_n pulsed low while in QRY with 2 words outstanding → all outputs at reset values immediately; the next header is parsed as a fresh query with id=0.
- SW_QPARSE_STATS_EN defined, 3 good + 2 bad headers → stat_queries=3, stat_rejects=2.
